// File: rtl/tomasulo_rs_age.sv
// Age-ordered Tomasulo reservation station: holds up to N ops, wakes operands from
// CDB_N broadcast ports and issues the oldest ready entry through cdb_req/cdb_gnt.
module tomasulo_rs_age #(
  parameter int N     = 4,
  parameter int CDB_N = 2,
  parameter int W     = 32,
  parameter int TAG_W = 4,
  parameter int OP_W  = 5,
  parameter int IMM_W = 16,
  parameter int ROB_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   sch_busy,
  input  logic [CDB_N-1:0]       cdb_vld,
  input  logic [CDB_N*TAG_W-1:0] cdb_tag,
  input  logic [CDB_N*W-1:0]     cdb_wdata,
  output logic                   cdb_req,
  input  logic                   cdb_gnt,
  input  logic                   dis_vld,
  input  logic [OP_W-1:0]        dis_op,
  input  logic [1:0]             dis_busy,
  input  logic [2*TAG_W-1:0]     dis_src_tag,
  input  logic [2*W-1:0]         dis_src_data,
  input  logic [TAG_W-1:0]       dis_dst_tag,
  input  logic [IMM_W-1:0]       dis_imm,
  input  logic [ROB_W-1:0]       dis_robid,
  output logic                   full_r,
  output logic [$clog2(N+1)-1:0] cnt_r,
  output logic                   iss_vld_r,
  output logic [OP_W-1:0]        iss_op,
  output logic [2*W-1:0]         iss_rdata,
  output logic [TAG_W-1:0]       iss_tag,
  output logic [IMM_W-1:0]       iss_imm,
  output logic [ROB_W-1:0]       iss_robid
);
  localparam int CNT_W = $clog2(N+1);

  logic [N-1:0]       valid_q, valid_d, ready_q, ready_d;
  logic [N-1:0]       age_q [N];
  logic [N-1:0]       age_d [N];
  logic [1:0]         busy_q [N];
  logic [1:0]         busy_d [N];
  logic [2*TAG_W-1:0] tag_q [N];
  logic [2*TAG_W-1:0] tag_d [N];
  logic [2*W-1:0]     data_q [N];
  logic [2*W-1:0]     data_d [N];
  logic [OP_W-1:0]    op_q [N];
  logic [OP_W-1:0]    op_d [N];
  logic [TAG_W-1:0]   dst_q [N];
  logic [TAG_W-1:0]   dst_d [N];
  logic [IMM_W-1:0]   imm_q [N];
  logic [IMM_W-1:0]   imm_d [N];
  logic [ROB_W-1:0]   rob_q [N];
  logic [ROB_W-1:0]   rob_d [N];

  logic               full_q, full_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               iss_vld_q, iss_vld_d;
  logic [OP_W-1:0]    iss_op_q, iss_op_d;
  logic [2*W-1:0]     iss_rdata_q, iss_rdata_d;
  logic [TAG_W-1:0]   iss_tag_q, iss_tag_d;
  logic [IMM_W-1:0]   iss_imm_q, iss_imm_d;
  logic [ROB_W-1:0]   iss_robid_q, iss_robid_d;

  logic [N-1:0]       alloc_oh, cand, sel;
  logic               alloc, grant;
  logic [1:0]         dis_hit;
  logic [2*W-1:0]     dis_byp_data;
  logic               multi_hit;

  // Allocation looks only at registered valid bits, so a slot freed this cycle waits a cycle.
  always_comb begin
    alloc_oh = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        alloc_oh    = '0;
        alloc_oh[i] = 1'b1;
      end
    end
  end

  assign alloc = dis_vld & ~full_q & ~flush;
  assign cand  = valid_q & ready_q;

  // An entry wins when no other candidate is older than it.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) begin
      sel[i] = cand[i];
      for (int j = 0; j < N; j++) begin
        if (cand[j] && age_q[j][i]) sel[i] = 1'b0;
      end
    end
  end

  assign cdb_req = (|cand) & ~sch_busy & ~flush;
  assign grant   = cdb_req & cdb_gnt;

  always_comb begin
    dis_hit      = '0;
    dis_byp_data = dis_src_data;
    for (int s = 0; s < 2; s++) begin
      for (int p = CDB_N-1; p >= 0; p--) begin
        if (dis_busy[s] && cdb_vld[p] &&
            cdb_tag[p*TAG_W +: TAG_W] == dis_src_tag[s*TAG_W +: TAG_W]) begin
          dis_hit[s]               = 1'b1;
          dis_byp_data[s*W +: W]   = cdb_wdata[p*W +: W];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      busy_d[i] = busy_q[i];
      tag_d[i]  = tag_q[i];
      data_d[i] = data_q[i];
      op_d[i]   = op_q[i];
      dst_d[i]  = dst_q[i];
      imm_d[i]  = imm_q[i];
      rob_d[i]  = rob_q[i];
      if (alloc && alloc_oh[i]) begin
        busy_d[i] = dis_busy & ~dis_hit;
        tag_d[i]  = dis_src_tag;
        data_d[i] = dis_byp_data;
        op_d[i]   = dis_op;
        dst_d[i]  = dis_dst_tag;
        imm_d[i]  = dis_imm;
        rob_d[i]  = dis_robid;
      end else if (valid_q[i]) begin
        for (int s = 0; s < 2; s++) begin
          for (int p = CDB_N-1; p >= 0; p--) begin
            if (busy_q[i][s] && cdb_vld[p] &&
                cdb_tag[p*TAG_W +: TAG_W] == tag_q[i][s*TAG_W +: TAG_W]) begin
              busy_d[i][s]           = 1'b0;
              data_d[i][s*W +: W]    = cdb_wdata[p*W +: W];
            end
          end
        end
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    ready_d = '0;
    age_d   = age_q;
    for (int i = 0; i < N; i++) begin
      ready_d[i] = valid_q[i] & ~(|busy_q[i]);
    end
    if (grant) begin
      valid_d = valid_d & ~sel;
      ready_d = ready_d & ~sel;
    end
    if (alloc) begin
      valid_d = valid_d | alloc_oh;
      for (int i = 0; i < N; i++) begin
        if (alloc_oh[i]) begin
          age_d[i] = '0;
          for (int j = 0; j < N; j++) begin
            if (valid_q[j]) age_d[j][i] = 1'b1;
          end
        end
      end
    end
    cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, alloc} - {{(CNT_W-1){1'b0}}, grant};
    full_d = (cnt_d == CNT_W'(N));
    if (flush) begin
      valid_d = '0;
      ready_d = '0;
      cnt_d   = '0;
      full_d  = 1'b0;
    end
  end

  always_comb begin
    iss_vld_d   = grant;
    iss_op_d    = iss_op_q;
    iss_rdata_d = iss_rdata_q;
    iss_tag_d   = iss_tag_q;
    iss_imm_d   = iss_imm_q;
    iss_robid_d = iss_robid_q;
    for (int i = 0; i < N; i++) begin
      if (grant && sel[i]) begin
        iss_op_d    = op_q[i];
        iss_rdata_d = data_q[i];
        iss_tag_d   = dst_q[i];
        iss_imm_d   = imm_q[i];
        iss_robid_d = rob_q[i];
      end
    end
  end

  always_comb begin
    multi_hit = 1'b0;
    for (int s = 0; s < 2; s++) begin
      for (int p = 0; p < CDB_N; p++) begin
        for (int r = p + 1; r < CDB_N; r++) begin
          if (dis_vld && dis_busy[s] && cdb_vld[p] && cdb_vld[r] &&
              cdb_tag[p*TAG_W +: TAG_W] == dis_src_tag[s*TAG_W +: TAG_W] &&
              cdb_tag[r*TAG_W +: TAG_W] == dis_src_tag[s*TAG_W +: TAG_W])
            multi_hit = 1'b1;
          for (int i = 0; i < N; i++) begin
            if (valid_q[i] && busy_q[i][s] && cdb_vld[p] && cdb_vld[r] &&
                cdb_tag[p*TAG_W +: TAG_W] == tag_q[i][s*TAG_W +: TAG_W] &&
                cdb_tag[r*TAG_W +: TAG_W] == tag_q[i][s*TAG_W +: TAG_W])
              multi_hit = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      ready_q   <= '0;
      full_q    <= 1'b0;
      cnt_q     <= '0;
      iss_vld_q <= 1'b0;
      for (int i = 0; i < N; i++) age_q[i] <= '0;
    end else begin
      valid_q   <= valid_d;
      ready_q   <= ready_d;
      full_q    <= full_d;
      cnt_q     <= cnt_d;
      iss_vld_q <= iss_vld_d;
      age_q     <= age_d;
    end
  end

  // Payload and issue fields carry no reset; they are qualified by valid/iss_vld.
  always_ff @(posedge clk) begin
    busy_q      <= busy_d;
    tag_q       <= tag_d;
    data_q      <= data_d;
    op_q        <= op_d;
    dst_q       <= dst_d;
    imm_q       <= imm_d;
    rob_q       <= rob_d;
    iss_op_q    <= iss_op_d;
    iss_rdata_q <= iss_rdata_d;
    iss_tag_q   <= iss_tag_d;
    iss_imm_q   <= iss_imm_d;
    iss_robid_q <= iss_robid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(dis_vld && full_q)) else $error("dispatch while station full");
      assert (!multi_hit) else $error("several CDB ports carry one pending tag");
    end
  end

  assign full_r    = full_q;
  assign cnt_r     = cnt_q;
  assign iss_vld_r = iss_vld_q;
  assign iss_op    = iss_op_q;
  assign iss_rdata = iss_rdata_q;
  assign iss_tag   = iss_tag_q;
  assign iss_imm   = iss_imm_q;
  assign iss_robid = iss_robid_q;

endmodule

// File: tb/tb_tomasulo_rs_age.sv
// Bench for tomasulo_rs_age: directed scenarios then random traffic, all checked
// against an oldest-first queue model of the station.
module tb_tomasulo_rs_age;
  localparam int N     = 4;
  localparam int CDB_N = 2;
  localparam int W     = 32;
  localparam int TAG_W = 4;
  localparam int OP_W  = 5;
  localparam int IMM_W = 16;
  localparam int ROB_W = 4;

  logic                   clk = 1'b0;
  logic                   rst, flush, sch_busy, cdb_req, cdb_gnt, dis_vld;
  logic [CDB_N-1:0]       cdb_vld;
  logic [CDB_N*TAG_W-1:0] cdb_tag;
  logic [CDB_N*W-1:0]     cdb_wdata;
  logic [OP_W-1:0]        dis_op;
  logic [1:0]             dis_busy;
  logic [2*TAG_W-1:0]     dis_src_tag;
  logic [2*W-1:0]         dis_src_data;
  logic [TAG_W-1:0]       dis_dst_tag;
  logic [IMM_W-1:0]       dis_imm;
  logic [ROB_W-1:0]       dis_robid;
  logic                   full_r, iss_vld_r;
  logic [$clog2(N+1)-1:0] cnt_r;
  logic [OP_W-1:0]        iss_op;
  logic [2*W-1:0]         iss_rdata;
  logic [TAG_W-1:0]       iss_tag;
  logic [IMM_W-1:0]       iss_imm;
  logic [ROB_W-1:0]       iss_robid;

  always #5 clk = ~clk;

  tomasulo_rs_age #(.N(N), .CDB_N(CDB_N), .W(W), .TAG_W(TAG_W), .OP_W(OP_W),
                    .IMM_W(IMM_W), .ROB_W(ROB_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .sch_busy(sch_busy),
    .cdb_vld(cdb_vld), .cdb_tag(cdb_tag), .cdb_wdata(cdb_wdata),
    .cdb_req(cdb_req), .cdb_gnt(cdb_gnt),
    .dis_vld(dis_vld), .dis_op(dis_op), .dis_busy(dis_busy),
    .dis_src_tag(dis_src_tag), .dis_src_data(dis_src_data),
    .dis_dst_tag(dis_dst_tag), .dis_imm(dis_imm), .dis_robid(dis_robid),
    .full_r(full_r), .cnt_r(cnt_r), .iss_vld_r(iss_vld_r),
    .iss_op(iss_op), .iss_rdata(iss_rdata), .iss_tag(iss_tag),
    .iss_imm(iss_imm), .iss_robid(iss_robid)
  );

  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [ROB_W-1:0]   rob;
    logic [TAG_W-1:0]   dst;
    logic [IMM_W-1:0]   imm;
    logic [1:0]         busy;
    logic [2*TAG_W-1:0] tags;
    logic [2*W-1:0]     data;
    logic               rdy;
  } ent_t;

  // Model entries kept oldest first; the head-most ready entry is the one to issue.
  ent_t             model[$];
  int               vectors = 0;
  int               miscompares = 0;
  logic             expIssV = 1'b0;
  logic [OP_W-1:0]  expOp;
  logic [2*W-1:0]   expRdata;
  logic [TAG_W-1:0] expTag;
  logic [IMM_W-1:0] expImm;
  logic [ROB_W-1:0] expRob;
  logic [ROB_W-1:0] issRob[$];
  logic [W-1:0]     issSrc0[$];

  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  function automatic int lowestHit(input logic [TAG_W-1:0] t);
    for (int p = 0; p < CDB_N; p++)
      if (cdb_vld[p] && cdb_tag[p*TAG_W +: TAG_W] == t) return p;
    return -1;
  endfunction

  task automatic modelEdge(input int selIdx, input bit grant);
    int   sizeBefore;
    int   h;
    ent_t e;
    if (rst || flush) begin
      model.delete();
      expIssV = 1'b0;
      return;
    end
    sizeBefore = model.size();
    expIssV    = grant;
    if (grant) begin
      e        = model[selIdx];
      expOp    = e.op;
      expRdata = e.data;
      expTag   = e.dst;
      expImm   = e.imm;
      expRob   = e.rob;
    end
    for (int k = 0; k < model.size(); k++) begin
      e     = model[k];
      e.rdy = (e.busy == 2'b00);
      for (int s = 0; s < 2; s++) begin
        if (e.busy[s]) begin
          h = lowestHit(e.tags[s*TAG_W +: TAG_W]);
          if (h >= 0) begin
            e.busy[s]         = 1'b0;
            e.data[s*W +: W]  = cdb_wdata[h*W +: W];
          end
        end
      end
      model[k] = e;
    end
    if (grant) model.delete(selIdx);
    if (dis_vld && sizeBefore < N) begin
      e.op   = dis_op;
      e.rob  = dis_robid;
      e.dst  = dis_dst_tag;
      e.imm  = dis_imm;
      e.tags = dis_src_tag;
      e.rdy  = 1'b0;
      e.busy = 2'b00;
      e.data = dis_src_data;
      for (int s = 0; s < 2; s++) begin
        if (dis_busy[s]) begin
          h = lowestHit(dis_src_tag[s*TAG_W +: TAG_W]);
          if (h >= 0) e.data[s*W +: W] = cdb_wdata[h*W +: W];
          else e.busy[s] = 1'b1;
        end
      end
      model.push_back(e);
    end
  endtask

  task automatic runCycle();
    int selIdx;
    bit expReq;
    #1;
    selIdx = -1;
    for (int k = 0; k < model.size(); k++)
      if (model[k].rdy && selIdx < 0) selIdx = k;
    expReq = (selIdx >= 0) && !sch_busy && !flush;
    checkOutput("cdb_req", cdb_req, expReq);
    @(posedge clk);
    modelEdge(selIdx, expReq && cdb_gnt);
    #1;
    checkOutput("cnt_r", cnt_r, model.size());
    checkOutput("full_r", full_r, model.size() == N);
    checkOutput("iss_vld_r", iss_vld_r, expIssV);
    if (expIssV) begin
      checkOutput("iss_op", iss_op, expOp);
      checkOutput("iss_rdata", iss_rdata, expRdata);
      checkOutput("iss_tag", iss_tag, expTag);
      checkOutput("iss_imm", iss_imm, expImm);
      checkOutput("iss_robid", iss_robid, expRob);
    end
    if (iss_vld_r) begin
      issRob.push_back(iss_robid);
      issSrc0.push_back(iss_rdata[W-1:0]);
    end
  endtask

  task automatic applyStimulus(input bit dv, input logic [OP_W-1:0] op,
                               input logic [1:0] busy, input logic [2*TAG_W-1:0] stag,
                               input logic [ROB_W-1:0] rob, input bit sb,
                               input bit gnt, input bit fl);
    dis_vld      = dv;
    dis_op       = op;
    dis_busy     = busy;
    dis_src_tag  = stag;
    dis_src_data = {$urandom, $urandom};
    dis_dst_tag  = TAG_W'($urandom);
    dis_imm      = IMM_W'($urandom);
    dis_robid    = rob;
    sch_busy     = sb;
    cdb_gnt      = gnt;
    flush        = fl;
    cdb_vld      = '0;
    cdb_tag      = '0;
    cdb_wdata    = {$urandom, $urandom};
  endtask

  task automatic idleCycles(input int n, input bit gnt);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b0, '0, 2'b00, '0, '0, 1'b0, gnt, 1'b0);
      runCycle();
    end
  endtask

  int               peak;
  logic             dv;
  logic [TAG_W-1:0] t0, t1;

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, '0, 2'b00, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_cnt", cnt_r, 0);
    checkOutput("reset_full", full_r, 0);
    checkOutput("reset_iss_vld", iss_vld_r, 0);
    checkOutput("reset_cdb_req", cdb_req, 0);
    rst = 1'b0;

    $display("[TB] in-order issue of four ready ops");
    issRob.delete();
    peak = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(k < 4, OP_W'(k + 1), 2'b00, '0, ROB_W'(k), 1'b0, 1'b1, 1'b0);
      runCycle();
      if (int'(cnt_r) > peak) peak = int'(cnt_r);
    end
    checkOutput("peak_cnt", peak, 2);
    checkOutput("issue_count", issRob.size(), 4);
    if (issRob.size() == 4)
      for (int k = 0; k < 4; k++) checkOutput("issue_order", issRob[k], k);

    $display("[TB] fill to full, grant one, refill");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, OP_W'($urandom), 2'b00, '0, ROB_W'(4 + k), 1'b0, 1'b0, 1'b0);
      runCycle();
    end
    idleCycles(1, 1'b0);
    checkOutput("full_after_fill", full_r, 1);
    checkOutput("cnt_after_fill", cnt_r, 4);
    idleCycles(1, 1'b1);
    checkOutput("full_after_grant", full_r, 0);
    applyStimulus(1'b1, OP_W'($urandom), 2'b00, '0, ROB_W'(8), 1'b0, 1'b0, 1'b0);
    runCycle();
    checkOutput("full_after_refill", full_r, 1);
    idleCycles(8, 1'b1);

    $display("[TB] younger ready op overtakes older waiting op");
    applyStimulus(1'b1, 5'd10, 2'b01, {4'h0, 4'h3}, 4'd5, 1'b0, 1'b0, 1'b0);
    runCycle();
    applyStimulus(1'b1, 5'd11, 2'b00, '0, 4'd6, 1'b0, 1'b0, 1'b0);
    runCycle();
    applyStimulus(1'b0, '0, 2'b00, '0, '0, 1'b0, 1'b0, 1'b0);
    cdb_vld   = 2'b10;
    cdb_tag   = {4'h3, 4'h0};
    cdb_wdata = {32'hDEAD_BEEF, 32'h0};
    runCycle();
    issRob.delete();
    issSrc0.delete();
    idleCycles(6, 1'b1);
    checkOutput("wake_issue_count", issRob.size(), 2);
    if (issRob.size() == 2) begin
      checkOutput("wake_first_rob", issRob[0], 6);
      checkOutput("wake_second_rob", issRob[1], 5);
      checkOutput("wake_src0", issSrc0[1], 32'hDEAD_BEEF);
    end

    $display("[TB] dispatch-time bypass");
    applyStimulus(1'b1, 5'd12, 2'b01, {4'h0, 4'h7}, 4'd7, 1'b0, 1'b0, 1'b0);
    cdb_vld   = 2'b01;
    cdb_tag   = {4'h0, 4'h7};
    cdb_wdata = {32'h0, 32'h0000_1234};
    runCycle();
    issSrc0.delete();
    idleCycles(4, 1'b1);
    checkOutput("bypass_issue_count", issSrc0.size(), 1);
    if (issSrc0.size() == 1) checkOutput("bypass_src0", issSrc0[0], 32'h0000_1234);

    $display("[TB] sch_busy holds off issue");
    applyStimulus(1'b1, 5'd13, 2'b00, '0, 4'd9, 1'b0, 1'b0, 1'b0);
    runCycle();
    applyStimulus(1'b1, 5'd14, 2'b00, '0, 4'd10, 1'b0, 1'b0, 1'b0);
    runCycle();
    issRob.delete();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, '0, 2'b00, '0, '0, 1'b1, 1'b1, 1'b0);
      runCycle();
    end
    checkOutput("busy_no_issue", issRob.size(), 0);
    idleCycles(4, 1'b1);
    checkOutput("busy_issue_count", issRob.size(), 2);
    if (issRob.size() == 2) checkOutput("busy_oldest_first", issRob[0], 9);

    $display("[TB] flush with grant and dispatch pending");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, OP_W'($urandom), 2'b00, '0, ROB_W'(11 + k), 1'b0, 1'b0, 1'b0);
      runCycle();
    end
    idleCycles(1, 1'b0);
    applyStimulus(1'b1, OP_W'($urandom), 2'b00, '0, 4'd14, 1'b0, 1'b1, 1'b1);
    runCycle();
    checkOutput("flush_cnt", cnt_r, 0);
    checkOutput("flush_full", full_r, 0);
    checkOutput("flush_iss_vld", iss_vld_r, 0);
    issRob.delete();
    applyStimulus(1'b1, OP_W'($urandom), 2'b00, '0, 4'd15, 1'b0, 1'b0, 1'b0);
    runCycle();
    idleCycles(4, 1'b1);
    checkOutput("post_flush_count", issRob.size(), 1);
    if (issRob.size() == 1) checkOutput("post_flush_rob", issRob[0], 15);

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      dv = (model.size() < N) && ($urandom_range(0, 1) == 1);
      applyStimulus(dv, OP_W'($urandom), 2'($urandom),
                    {TAG_W'($urandom_range(0, 3)), TAG_W'($urandom_range(0, 3))},
                    ROB_W'($urandom), $urandom_range(0, 4) == 0,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
      t0      = TAG_W'($urandom_range(0, 3));
      t1      = t0 ^ TAG_W'($urandom_range(1, 3));
      cdb_vld = 2'($urandom);
      cdb_tag = {t1, t0};
      runCycle();
    end
    applyStimulus(1'b0, '0, 2'b00, '0, '0, 1'b0, 1'b0, 1'b1);
    runCycle();
    idleCycles(2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
